irq_ctrl8: RTL and testbench
============================

IRQ_CTRL8 -- requirements
Module: irq_ctrl8

Interface
REQ-001 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 req  input  8  interrupt request lines; bit 7 highest priority, bit 0 lowest.
REQ-004 mask_we  input  1  when 1, mask register SHALL load mask_din at the clock edge.
REQ-005 mask_din  input  8  new mask value; 1 = line masked.
REQ-006 int_ack  input  1  CPU acknowledge; honoured only in state ASSERT.
REQ-007 eoi  input  1  end-of-interrupt; honoured only in state SERVICE.
REQ-008 int_req  output  1  interrupt request to CPU; 1 only in state ASSERT.
REQ-009 int_vec  output  3  encoded line number of the current request or service.
REQ-010 pending  output  8  pending register.
REQ-011 in_service  output  1  1 only in state SERVICE.
REQ-012 idle  output  1  1 when (pending & ~mask) == 8'h00.

Function
REQ-013 Pending-set rule SHALL be compile-selected (REQ-033/034); a pending bit SHALL remain set until cleared by acknowledge or reset.
REQ-014 Masking SHALL NOT clear pending bits; masked bits SHALL NOT take part in arbitration.
REQ-015 Arbitration SHALL select the highest-numbered set bit of (pending & ~mask), encoded to 3 bits; all-zero gives idle=1.
REQ-016 FSM states SHALL be IDLE, ASSERT, SERVICE; reset state IDLE.
REQ-017 IDLE -> ASSERT at the first edge where idle=0; int_vec SHALL be captured at that edge.
REQ-018 In ASSERT, int_vec SHALL stay frozen while int_ack=0, even if higher-priority requests arrive or the mask changes.
REQ-019 ASSERT with int_ack=1: at that edge, pending[int_vec] SHALL clear, state -> SERVICE, int_req -> 0, int_vec held.
REQ-020 SERVICE with eoi=1: state -> IDLE at that edge; a further request may assert int_req no earlier than the next edge.
REQ-021 int_ack outside ASSERT and eoi outside SERVICE SHALL be ignored; int_ack and eoi together in ASSERT SHALL act as int_ack only.
REQ-022 Same-edge set and clear of one pending bit: set SHALL win (bit stays 1).
REQ-023 Latency: qualifying request sampled at edge k -> pending bit 1 after edge k -> int_req 1 after edge k+1 (from IDLE, line unmasked).
REQ-024 New requests SHALL be latched into pending in every state.
REQ-025 mask_we SHALL take effect at its edge; idle SHALL reflect the new mask from the following cycle.

Reset
REQ-026 With rst=1 at an edge: state IDLE, pending 8'h00, mask 8'hFF, captured vector 3'b000, edge-history register 8'h00.
REQ-027 After reset: int_req 0, int_vec 3'b000, in_service 0, idle 1.
REQ-028 Reset SHALL take priority over mask_we, int_ack, eoi and request sampling in the same cycle.
REQ-029 Reset mid-ASSERT or mid-SERVICE SHALL abandon the transaction; no pending bit survives.

Configuration
REQ-030 Macro IRQ_CTRL8_EDGE_EN SHALL select request sensitivity.
REQ-031 Edge-history register req_d SHALL load req every edge when the macro is defined.
REQ-032 The history register SHALL not exist when the macro is undefined.
REQ-033 Defined: pending[i] SHALL set only on a rising edge (req[i]=1 and req_d[i]=0); a held-high line SHALL trigger once.
REQ-034 Undefined: pending[i] SHALL set at every edge where req[i]=1; a line held high SHALL re-pend on the edge after acknowledge.
REQ-035 All other behaviour SHALL be identical in both builds.

Verification
REQ-036 Reset, then mask_we with 8'h00, then req=8'h20 for 1 cycle -> pending 8'h20, then int_req=1, int_vec=3'b101 one edge later.
REQ-037 Mask 8'h00, req=8'h05 -> int_vec=3'b010; int_ack -> pending 8'h01, in_service=1; eoi -> int_vec=3'b000, int_req=1.
REQ-038 In ASSERT with int_vec=3'b001, pulse req[7] -> int_vec stays 3'b001; after int_ack and eoi, next int_vec=3'b111.
REQ-039 Mask 8'h80, req=8'h80 -> pending 8'h80, idle=1, int_req=0; write mask 8'h00 -> int_req=1, int_vec=3'b111.
REQ-040 Hold req[3]=1 through ack/eoi: edge build -> no second int_req; level build -> second int_req with int_vec=3'b011.
REQ-041 rst=1 while in SERVICE with pending 8'hC0 -> pending 8'h00, mask 8'hFF, int_req 0, in_service 0, idle 1.

Source files
------------

// File: rtl/irq_ctrl8.sv
// irq_ctrl8 -- 8-line priority interrupt controller with mask, pending latch and a
// three-state IDLE / ASSERT / SERVICE handshake towards the CPU.
//
// Build option:
//   IRQ_CTRL8_EDGE_EN  defined   -> requests are rising-edge sensitive (history register req_d)
//                      undefined -> requests are level sensitive (default)
//
// Ports:
//   clk        in   1  clock, all state on rising edge
//   rst        in   1  synchronous active-high reset
//   req        in   8  request lines, bit 7 highest priority
//   mask_we    in   1  load mask_din into the mask register
//   mask_din   in   8  new mask value, 1 = masked
//   int_ack    in   1  CPU acknowledge (ASSERT only)
//   eoi        in   1  end of interrupt (SERVICE only)
//   int_req    out  1  interrupt request to CPU (ASSERT)
//   int_vec    out  3  captured line number of current request / service
//   pending    out  8  pending register
//   in_service out  1  high in SERVICE
//   idle       out  1  no unmasked pending line
module irq_ctrl8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mask_we,
  input  logic [7:0] mask_din,
  input  logic       int_ack,
  input  logic       eoi,
  output logic       int_req,
  output logic [2:0] int_vec,
  output logic [7:0] pending,
  output logic       in_service,
  output logic       idle
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAssert  = 2'd1;
  localparam logic [1:0] StService = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q;
  logic [2:0] vec_q, vec_d;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic [7:0] active;
  logic [2:0] arb_vec;

`ifdef IRQ_CTRL8_EDGE_EN
  logic [7:0] req_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_d <= 8'h00;
    end else begin
      req_d <= req;
    end
  end

  assign set_vec = req & ~req_d;
`else
  assign set_vec = req;
`endif

  assign active = pending_q & ~mask_q;

  // Highest-numbered unmasked pending line wins.
  always_comb begin
    arb_vec = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (active[i]) arb_vec = 3'(i);
    end
  end

  // Acknowledge clears the captured line; a same-edge set overrides it.
  always_comb begin
    clr_vec = 8'h00;
    if (state_q == StAssert && int_ack) clr_vec = 8'h01 << vec_q;
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      StIdle: begin
        if (active != 8'h00) begin
          state_d = StAssert;
          vec_d   = arb_vec;
        end
      end
      StAssert: begin
        if (int_ack) state_d = StService;
      end
      StService: begin
        if (eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 8'h00;
      mask_q    <= 8'hFF;
      vec_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      vec_q     <= vec_d;
      if (mask_we) mask_q <= mask_din;
    end
  end

  assign int_req    = (state_q == StAssert);
  assign in_service = (state_q == StService);
  assign int_vec    = vec_q;
  assign pending    = pending_q;
  assign idle       = (active == 8'h00);

endmodule

// File: tb/tb_irq_ctrl8.sv
// Directed self-checking bench for irq_ctrl8. Observed outputs are packed as
// {int_req, int_vec, in_service, idle, pending} and compared per step.
module tb_irq_ctrl8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       mask_we = 1'b0;
  logic [7:0] mask_din = 8'h00;
  logic       int_ack = 1'b0;
  logic       eoi = 1'b0;
  logic       int_req;
  logic [2:0] int_vec;
  logic [7:0] pending;
  logic       in_service;
  logic       idle;
  logic [13:0] obs;

  int total = 0;
  int bad = 0;

  irq_ctrl8 dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mask_we    (mask_we),
    .mask_din   (mask_din),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .pending    (pending),
    .in_service (in_service),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  assign obs = {int_req, int_vec, in_service, idle, pending};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; mask_we = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_mask(input logic [7:0] m);
    mask_we = 1'b1; mask_din = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    rst = 1'b1; req = 8'hFF; mask_we = 1'b1; mask_din = 8'h00; int_ack = 1'b1; eoi = 1'b1;
    tick();
    exp = {1'b0, 3'd0, 1'b0, 1'b1, 8'h00};
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_prio got=%h want=%h", obs, exp); end
    rst = 1'b0; req = 8'h00; mask_we = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    tick();
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_idle got=%h want=%h", obs, exp); end
    req = 8'h01;
    tick();
    req = 8'h00;
    exp = {1'b0, 3'd0, 1'b0, 1'b1, 8'h01};
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_mask_ff got=%h want=%h", obs, exp); end
    tick();
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_no_assert got=%h want=%h", obs, exp); end
  endtask

  task automatic test_basic();
    logic [13:0] exp;
    do_reset();
    set_mask(8'h00);
    req = 8'h20;
    tick();
    req = 8'h00;
    exp = {1'b0, 3'd0, 1'b0, 1'b0, 8'h20};
    total++; if (obs !== exp) begin bad++; $display("FAIL basic_pend got=%h want=%h", obs, exp); end
    tick();
    exp = {1'b1, 3'd5, 1'b0, 1'b0, 8'h20};
    total++; if (obs !== exp) begin bad++; $display("FAIL basic_assert got=%h want=%h", obs, exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    exp = {1'b0, 3'd5, 1'b1, 1'b1, 8'h00};
    total++; if (obs !== exp) begin bad++; $display("FAIL basic_ack got=%h want=%h", obs, exp); end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    exp = {1'b0, 3'd5, 1'b0, 1'b1, 8'h00};
    total++; if (obs !== exp) begin bad++; $display("FAIL basic_eoi got=%h want=%h", obs, exp); end
  endtask

  task automatic test_priority();
    logic [13:0] exp;
    do_reset();
    set_mask(8'h00);
    req = 8'h05;
    tick();
    req = 8'h00;
    exp = {1'b0, 3'd0, 1'b0, 1'b0, 8'h05};
    total++; if (obs !== exp) begin bad++; $display("FAIL prio_pend got=%h want=%h", obs, exp); end
    tick();
    exp = {1'b1, 3'd2, 1'b0, 1'b0, 8'h05};
    total++; if (obs !== exp) begin bad++; $display("FAIL prio_assert got=%h want=%h", obs, exp); end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    total++; if (obs !== exp) begin bad++; $display("FAIL prio_eoi_ignored got=%h want=%h", obs, exp); end
    int_ack = 1'b1; eoi = 1'b1;
    tick();
    eoi = 1'b0;
    exp = {1'b0, 3'd2, 1'b1, 1'b0, 8'h01};
    total++; if (obs !== exp) begin bad++; $display("FAIL prio_ack_eoi got=%h want=%h", obs, exp); end
    tick();
    int_ack = 1'b0;
    total++; if (obs !== exp) begin bad++; $display("FAIL prio_ack_ignored got=%h want=%h", obs, exp); end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    exp = {1'b0, 3'd2, 1'b0, 1'b0, 8'h01};
    total++; if (obs !== exp) begin bad++; $display("FAIL prio_eoi got=%h want=%h", obs, exp); end
    tick();
    exp = {1'b1, 3'd0, 1'b0, 1'b0, 8'h01};
    total++; if (obs !== exp) begin bad++; $display("FAIL prio_next got=%h want=%h", obs, exp); end
  endtask

  task automatic test_freeze();
    logic [13:0] exp;
    do_reset();
    set_mask(8'h00);
    req = 8'h02;
    tick();
    req = 8'h00;
    tick();
    exp = {1'b1, 3'd1, 1'b0, 1'b0, 8'h02};
    total++; if (obs !== exp) begin bad++; $display("FAIL frz_assert got=%h want=%h", obs, exp); end
    req = 8'h80;
    tick();
    req = 8'h00;
    exp = {1'b1, 3'd1, 1'b0, 1'b0, 8'h82};
    total++; if (obs !== exp) begin bad++; $display("FAIL frz_hi_req got=%h want=%h", obs, exp); end
    set_mask(8'h02);
    total++; if (obs !== exp) begin bad++; $display("FAIL frz_mask got=%h want=%h", obs, exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    exp = {1'b0, 3'd1, 1'b1, 1'b0, 8'h80};
    total++; if (obs !== exp) begin bad++; $display("FAIL frz_ack got=%h want=%h", obs, exp); end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    exp = {1'b1, 3'd7, 1'b0, 1'b0, 8'h80};
    total++; if (obs !== exp) begin bad++; $display("FAIL frz_next got=%h want=%h", obs, exp); end
  endtask

  task automatic test_mask();
    logic [13:0] exp;
    do_reset();
    set_mask(8'h80);
    req = 8'h80;
    tick();
    req = 8'h00;
    exp = {1'b0, 3'd0, 1'b0, 1'b1, 8'h80};
    total++; if (obs !== exp) begin bad++; $display("FAIL mask_pend got=%h want=%h", obs, exp); end
    tick();
    total++; if (obs !== exp) begin bad++; $display("FAIL mask_hold got=%h want=%h", obs, exp); end
    set_mask(8'h00);
    exp = {1'b0, 3'd0, 1'b0, 1'b0, 8'h80};
    total++; if (obs !== exp) begin bad++; $display("FAIL mask_unmask got=%h want=%h", obs, exp); end
    tick();
    exp = {1'b1, 3'd7, 1'b0, 1'b0, 8'h80};
    total++; if (obs !== exp) begin bad++; $display("FAIL mask_assert got=%h want=%h", obs, exp); end
  endtask

  task automatic test_hold();
    logic [13:0] exp;
    do_reset();
    set_mask(8'h00);
    req = 8'h08;
    tick();
    tick();
    exp = {1'b1, 3'd3, 1'b0, 1'b0, 8'h08};
    total++; if (obs !== exp) begin bad++; $display("FAIL hold_assert got=%h want=%h", obs, exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
`ifdef IRQ_CTRL8_EDGE_EN
    exp = {1'b0, 3'd3, 1'b1, 1'b1, 8'h00};
`else
    exp = {1'b0, 3'd3, 1'b1, 1'b0, 8'h08};
`endif
    total++; if (obs !== exp) begin bad++; $display("FAIL hold_ack got=%h want=%h", obs, exp); end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
`ifdef IRQ_CTRL8_EDGE_EN
    exp = {1'b0, 3'd3, 1'b0, 1'b1, 8'h00};
`else
    exp = {1'b1, 3'd3, 1'b0, 1'b0, 8'h08};
`endif
    total++; if (obs !== exp) begin bad++; $display("FAIL hold_second got=%h want=%h", obs, exp); end
    req = 8'h00;
  endtask

  task automatic test_reset_mid();
    logic [13:0] exp;
    do_reset();
    set_mask(8'h00);
    req = 8'hC0;
    tick();
    req = 8'h00;
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    req = 8'h80;
    tick();
    req = 8'h00;
    exp = {1'b0, 3'd7, 1'b1, 1'b0, 8'hC0};
    total++; if (obs !== exp) begin bad++; $display("FAIL mid_service got=%h want=%h", obs, exp); end
    rst = 1'b1; req = 8'hFF; mask_we = 1'b1; mask_din = 8'h00; int_ack = 1'b1; eoi = 1'b1;
    tick();
    rst = 1'b0; req = 8'h00; mask_we = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    exp = {1'b0, 3'd0, 1'b0, 1'b1, 8'h00};
    total++; if (obs !== exp) begin bad++; $display("FAIL mid_reset got=%h want=%h", obs, exp); end
    req = 8'h01;
    tick();
    req = 8'h00;
    exp = {1'b0, 3'd0, 1'b0, 1'b1, 8'h01};
    total++; if (obs !== exp) begin bad++; $display("FAIL mid_mask_ff got=%h want=%h", obs, exp); end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_priority();
    test_freeze();
    test_mask();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
